// File: rtl/tinyacc_pkg.sv
// Shared constants and types for the systolic instruction path.
package tinyacc_pkg;

    localparam int INSTR_W = 71;

    // Opcode field position inside a systolic instruction.
    localparam int OP_MSB = 70;
    localparam int OP_LSB = 68;

    // Local opcode: rewinds the output-buffer write index, never sent to the core.
    localparam logic [2:0] OP_SYNC = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    function automatic logic [2:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x WIDTH instruction FIFO with a combinational head output.
// Push is ignored when full and pop is ignored when empty.
module instr_fifo
    import tinyacc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INSTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage write; entries are only meaningful while counted.
    // NOTE: the array has no reset -- occupancy is tracked by count_q, so clearing
    // the storage would add reset fan-out and stop it mapping onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is 2^n.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/systolic_dispatcher.sv
// Queues host instructions and issues them one at a time to the systolic core,
// retires local SYNC ops, tracks the output-buffer write index and flags
// handshake protocol errors.
module systolic_dispatcher
    import tinyacc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int OIDX_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_valid,
    input  logic [INSTR_W-1:0] host_instr,
    output logic               host_ready,
    input  logic               A_ready,
    input  logic               B_ready,
    output logic               core_instr_valid,
    output logic [INSTR_W-1:0] core_instr,
    input  logic               core_ack,
    input  logic               core_done,
    input  logic               core_DO_valid,
    output logic [OIDX_W-1:0]  out_index,
    output logic [7:0]         done_cnt,
    output logic               busy,
    output logic               idle,
    output logic               err
);

    state_e               state_q, state_d;
    logic [OIDX_W-1:0]    out_index_q, out_index_d;
    logic [7:0]           done_cnt_q, done_cnt_d;
    logic                 err_q, err_d;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [INSTR_W-1:0]   fifo_head;
    logic                 sync_retire, done_evt;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (host_valid && host_ready),
        .data_i  (host_instr),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // No pass-through: acceptance depends only on occupancy.
    assign host_ready = !fifo_full;
    assign core_instr = fifo_head;

    // State register and all counters/flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_index_q <= '0;
            done_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_index_q <= out_index_d;
            done_cnt_q  <= done_cnt_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: SYNC retire, ready-gated issue, ack pop, done completion.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d     = state_q;
        fifo_pop    = 1'b0;
        sync_retire = 1'b0;
        done_evt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (instr_op(fifo_head) == OP_SYNC) begin
                        sync_retire = 1'b1;
                        fifo_pop    = 1'b1;
                    end else if (A_ready && B_ready) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (core_ack) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    done_evt = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Index, completion counter and sticky error; SYNC clear beats an increment.
    always_comb begin
        out_index_d = out_index_q;
        if (sync_retire) begin
            out_index_d = '0;
        end else if (core_DO_valid) begin
            out_index_d = out_index_q + 1'b1;
        end
        done_cnt_d = done_evt ? done_cnt_q + 1'b1 : done_cnt_q;
        err_d = err_q
              | (core_done && (state_q != ST_RUN))
              | (core_ack  && (state_q != ST_ISSUE));
    end

    // Outputs decoded from registered state only.
    always_comb begin
        core_instr_valid = (state_q == ST_ISSUE);
        busy             = (state_q != ST_IDLE);
        idle             = (state_q == ST_IDLE) && fifo_empty;
    end

    assign out_index = out_index_q;
    assign done_cnt  = done_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_systolic_dispatcher.sv
// Self-checking bench for systolic_dispatcher: issued payloads are checked by
// a scoreboard monitor; index, counters and flags against a simple model.
module tb_systolic_dispatcher;
    import tinyacc_pkg::*;

    localparam int DEPTH  = 4;
    localparam int OIDX_W = 10;

    typedef logic [INSTR_W-1:0] instr_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               host_valid;
    instr_t             host_instr;
    logic               host_ready;
    logic               A_ready, B_ready;
    logic               core_instr_valid;
    instr_t             core_instr;
    logic               core_ack, core_done, core_DO_valid;
    logic [OIDX_W-1:0]  out_index;
    logic [7:0]         done_cnt;
    logic               busy, idle, err;

    always #5 clk = ~clk;

    systolic_dispatcher #(.DEPTH(DEPTH), .OIDX_W(OIDX_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .host_valid       (host_valid),
        .host_instr       (host_instr),
        .host_ready       (host_ready),
        .A_ready          (A_ready),
        .B_ready          (B_ready),
        .core_instr_valid (core_instr_valid),
        .core_instr       (core_instr),
        .core_ack         (core_ack),
        .core_done        (core_done),
        .core_DO_valid    (core_DO_valid),
        .out_index        (out_index),
        .done_cnt         (done_cnt),
        .busy             (busy),
        .idle             (idle),
        .err              (err)
    );

    int     n_checks = 0;
    int     n_fails  = 0;
    instr_t exp_q[$];      // instructions the core must see, in order
    int     exp_oidx;      // modelled write index
    int     exp_done;      // modelled completion count
    bit     ok, ok5, seen;
    instr_t p [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t rand_instr();
        instr_t v;
        v = instr_t'({$urandom(), $urandom(), $urandom()});
        v[OP_MSB:OP_LSB] = 3'($urandom_range(0, 6));
        return v;
    endfunction

    function automatic instr_t sync_instr();
        instr_t v;
        v = rand_instr();
        v[OP_MSB:OP_LSB] = OP_SYNC;
        return v;
    endfunction

    // Offer one instruction until accepted; only non-SYNC ops are expected at the core.
    task automatic push(input instr_t instr, output bit accepted);
        accepted   = 1'b0;
        host_valid = 1'b1;
        host_instr = instr;
        for (int i = 0; i < 200; i++) begin
            if (host_ready) begin
                accepted = 1'b1;
                if (instr[OP_MSB:OP_LSB] != OP_SYNC) exp_q.push_back(instr);
                tick();
                break;
            end
            tick();
        end
        host_valid = 1'b0;
        if (!accepted) check("push_accept", 128'(host_ready), 128'(1));
    endtask

    // Behave as the core for one instruction.
    task automatic serve(input int ack_dly, input int done_dly, input int n_do);
        for (int i = 0; i < 100 && !core_instr_valid; i++) tick();
        check("serve_valid", 128'(core_instr_valid), 128'(1));
        repeat (ack_dly) tick();
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
        check("valid_low_after_ack", 128'(core_instr_valid), 128'(0));
        check("busy_in_run", 128'(busy), 128'(1));
        for (int i = 0; i < done_dly; i++) begin
            core_DO_valid = (i < n_do);
            tick();
        end
        core_DO_valid = 1'b0;
        exp_oidx = (exp_oidx + n_do) % (1 << OIDX_W);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        exp_done = (exp_done + 1) % 256;
        check("idle_after_done", 128'(busy), 128'(0));
    endtask

    task automatic pulse_do(input int n);
        core_DO_valid = 1'b1;
        repeat (n) tick();
        core_DO_valid = 1'b0;
        exp_oidx = (exp_oidx + n) % (1 << OIDX_W);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_host_ready"}, 128'(host_ready), 128'(1));
        check({tag, "_idle"},       128'(idle),       128'(1));
        check({tag, "_busy"},       128'(busy),       128'(0));
        check({tag, "_valid"},      128'(core_instr_valid), 128'(0));
        check({tag, "_out_index"},  128'(out_index),  128'(0));
        check({tag, "_done_cnt"},   128'(done_cnt),   128'(0));
        check({tag, "_err"},        128'(err),        128'(0));
    endtask

    // Scoreboard monitor: each new issue pops the next expected payload,
    // which must then stay on core_instr for the whole offer.
    initial begin : monitor
        logic   prev_valid;
        instr_t cur_exp;
        prev_valid = 1'b0;
        cur_exp    = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_valid = 1'b0;
            end else begin
                if (core_instr_valid) begin
                    if (!prev_valid) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fails++;
                            $display("FAIL unexpected_issue: got 0x%0h, expected no issue", core_instr);
                        end else begin
                            cur_exp = exp_q.pop_front();
                            if (core_instr !== cur_exp) begin
                                n_fails++;
                                $display("FAIL issue_payload: got 0x%0h, expected 0x%0h", core_instr, cur_exp);
                            end
                        end
                    end else begin
                        check("issue_stable", 128'(core_instr), 128'(cur_exp));
                    end
                end
                prev_valid = core_instr_valid;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b0; host_valid = 1'b0; host_instr = '0;
        A_ready = 1'b1; B_ready = 1'b1;
        core_ack = 1'b0; core_done = 1'b0; core_DO_valid = 1'b0;
        exp_oidx = 0; exp_done = 0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b1;
        tick();

        // Basic flow and first-issue latency.
        push(rand_instr(), ok);
        check("valid_before_issue", 128'(core_instr_valid), 128'(0));
        tick();
        check("valid_after_issue", 128'(core_instr_valid), 128'(1));
        serve(2, 20, 16);
        tick();
        check("basic_out_index", 128'(out_index), 128'(exp_oidx));
        check("basic_done_cnt",  128'(done_cnt),  128'(exp_done));
        check("basic_idle",      128'(idle),      128'(1));
        check("basic_err",       128'(err),       128'(0));

        // Ready gating.
        A_ready = 1'b0;
        push(rand_instr(), ok);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (core_instr_valid) seen = 1'b1;
        end
        check("gated_valid", 128'(seen), 128'(0));
        A_ready = 1'b1;
        check("gate_open_before_edge", 128'(core_instr_valid), 128'(0));
        tick();
        check("gate_open_after_edge", 128'(core_instr_valid), 128'(1));
        serve(1, 5, 0);

        // Backpressure: core stalled while four fill the FIFO.
        foreach (p[i]) p[i] = rand_instr();
        for (int i = 0; i < 4; i++) begin
            push(p[i], ok);
            if (i == 2) check("ready_after_3", 128'(host_ready), 128'(1));
        end
        check("ready_low_when_full", 128'(host_ready), 128'(0));
        fork
            push(p[4], ok5);
            repeat (5) serve(1, 3, 1);
        join
        check("fifth_accepted", 128'(ok5), 128'(1));
        tick();
        check("bp_done_cnt", 128'(done_cnt), 128'(exp_done));

        // SYNC rewinds the index, beating a same-cycle increment.
        pulse_do(37 - exp_oidx);
        check("oidx_37", 128'(out_index), 128'(37));
        push(sync_instr(), ok);
        check("oidx_before_sync", 128'(out_index), 128'(37));
        core_DO_valid = 1'b1;
        push(rand_instr(), ok);
        core_DO_valid = 1'b0;
        exp_oidx = 0;
        check("oidx_after_sync", 128'(out_index), 128'(exp_oidx));
        serve(1, 4, 3);
        tick();
        check("oidx_after_run", 128'(out_index), 128'(exp_oidx));

        // Back-to-back SYNCs retire one per cycle.
        push(sync_instr(), ok);
        push(sync_instr(), ok);
        check("sync2_pending", 128'(idle), 128'(0));
        tick();
        exp_oidx = 0;
        check("sync2_retired", 128'(idle), 128'(1));
        check("sync2_oidx", 128'(out_index), 128'(exp_oidx));

        // Index wrap.
        pulse_do(1025);
        check("oidx_wrap", 128'(out_index), 128'(exp_oidx));

        // Stray done in IDLE is an error and otherwise ignored.
        check("err_clear", 128'(err), 128'(0));
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("err_set", 128'(err), 128'(1));
        check("err_done_cnt", 128'(done_cnt), 128'(exp_done));
        check("err_idle", 128'(idle), 128'(1));
        repeat (5) tick();
        check("err_sticky", 128'(err), 128'(1));

        // Reset mid-RUN with three queued.
        for (int i = 0; i < 4; i++) push(rand_instr(), ok);
        for (int i = 0; i < 20 && !core_instr_valid; i++) tick();
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
        check("run_busy", 128'(busy), 128'(1));
        check("run_ready_3q", 128'(host_ready), 128'(1));
        rst = 1'b0;
        #1;
        exp_q.delete();
        exp_oidx = 0;
        exp_done = 0;
        check_reset_values("midrun_reset");
        tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (core_instr_valid) seen = 1'b1;
        end
        check("no_issue_after_reset", 128'(seen), 128'(0));
        check("idle_after_reset", 128'(idle), 128'(1));
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/systolic_dispatcher.md
# systolic_dispatcher

Instruction dispatcher placed between the host instruction port and the Systolic core. It queues 71-bit systolic instructions in a small FIFO and issues them one at a time over the core's `instr_valid`/`ack` handshake, only once both global buffers report ready. It waits for `done` before issuing the next instruction. It also owns the output-buffer write index that addresses `GBUFF_O_uni`/`GBUFF_O_wei`, and executes a local SYNC opcode that rewinds that index.

## Interface
- `INSTR_W`, 71, instruction width; fields per the systolic format: op[70:68], uni_src_addr[67:58], uni_channel/row/col, wei_src_addr[33:24], wei_channel/row/col.
- `DEPTH`, 4, FIFO entries; must be a power of 2, ≥ 2.
- `OIDX_W`, 10, output write-index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `host_valid`  in  1  host offers an instruction.
- `host_instr`  in  INSTR_W  instruction payload.
- `host_ready`  out  1  FIFO can accept; equals !full.
- `A_ready`  in  1  uni buffer loaded.
- `B_ready`  in  1  wei buffer loaded.
- `core_instr_valid`  out  1  instruction offered to core (drives Systolic config_valid).
- `core_instr`  out  INSTR_W  FIFO head.
- `core_ack`  in  1  core accepted instruction.
- `core_done`  in  1  core finished current instruction.
- `core_DO_valid`  in  1  core output word valid.
- `out_index`  out  OIDX_W  output-buffer write address.
- `done_cnt`  out  8  completed core instructions.
- `busy`  out  1  state != IDLE.
- `idle`  out  1  state == IDLE and FIFO empty.
- `err`  out  1  sticky protocol error.

## Operation
- **FIFO**
  - Push when `host_valid && host_ready`.
  - Pop on `core_ack` in ISSUE, or on a SYNC retire in IDLE.
  - `host_ready` depends only on full. There is no pass-through when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
- **FSM states:** IDLE, ISSUE, RUN.
  - IDLE, head op == 3'b111 (SYNC): pop, clear `out_index` to 0, stay IDLE. Does not wait for A/B ready and is never sent to the core.
  - IDLE, FIFO non-empty, head op != SYNC, `A_ready && B_ready`: go to ISSUE.
  - ISSUE: `core_instr_valid` = 1 and `core_instr` = head, held stable. On `core_ack`: pop and go to RUN.
  - RUN: wait for `core_done`. On `core_done`: `done_cnt`++ (wraps at 255), go to IDLE.
- **Output index**
  - `out_index`++ on every `core_DO_valid`, wrapping at 2^OIDX_W − 1 → 0.
  - SYNC clear takes priority over a same-cycle increment.
- **Errors (sticky, cleared only by reset)**
  - `err` set on `core_done` outside RUN.
  - `err` set on `core_ack` outside ISSUE.
  - The offending event is otherwise ignored; state and counters are unchanged.
- **Reset:** FIFO empty, state IDLE, `out_index` = 0, `done_cnt` = 0, `err` = 0, `core_instr_valid` = 0, `busy` = 0, `idle` = 1, `host_ready` = 1. Reset mid-operation discards queued and in-flight instructions.

## Timing
- All state is registered. `core_instr_valid` and `busy` are decoded from the state register, so they are glitch-free.
- `core_instr` is the FIFO head read combinationally; it is stable throughout ISSUE.
- Push accepted at edge t → FIFO non-empty after t → IDLE→ISSUE at edge t+1 (if ready) → `core_instr_valid` high in the cycle after t+1.
- `core_ack` sampled at edge k → `core_instr_valid` low after k.
- `core_done` at edge d → IDLE after d. The next ISSUE is no earlier than edge d+1, so there is at least one idle cycle between instructions.
- `core_ack` and `core_done` asserted in the same cycle during ISSUE: ack is taken, done is flagged as an error.
- A SYNC retires in 1 cycle; consecutive SYNCs retire 1 per cycle.
- `A_ready`/`B_ready` are sampled only in IDLE. Deassertion during ISSUE or RUN has no effect.

## Structure
- Shared package `tinyacc_pkg` holds:
  - `INSTR_W`;
  - op field LSB/MSB constants;
  - `OP_SYNC` = 3'b111;
  - state encoding typedef (IDLE = 0, ISSUE = 1, RUN = 2).
- One sub-module, `instr_fifo`: synchronous DEPTH×INSTR_W FIFO with push/pop/full/empty and a head output.
- FSM, index and counters live in the top of `systolic_dispatcher`.

## Test plan
- **Basic flow:** push one instr, A/B ready, core acks 2 cycles after valid, done 20 cycles later with 16 `DO_valid` pulses → `out_index` = 16, `done_cnt` = 1, `idle` = 1, `err` = 0.
- **Ready gating:** push with `A_ready` = 0 for 10 cycles → `core_instr_valid` stays 0. Raise `A_ready` → valid rises the cycle after the next edge.
- **Backpressure:** push 5 instrs back-to-back with core stalled → `host_ready` low after the 4th. All 4 are issued in order, verified by payload, then the 5th is accepted.
- **SYNC:** `out_index` = 37, push SYNC then a normal instr → `out_index` = 0 one cycle after SYNC. SYNC never appears on `core_instr`; the next instr issues normally.
- **Wrap and error:** 1025 `DO_valid` pulses → `out_index` = 1. Stray `core_done` in IDLE → `err` = 1 and stays 1 until reset.
- **Reset mid-RUN:** 3 queued, 1 running, assert `rst` → all outputs at reset values immediately. After release, no issue occurs without new pushes.
